mips_execute_alu_stage: RTL

MIPS_EXECUTE_ALU_STAGE -- requirements
Module: Mips_Execute_Alu_stage

---
 rtl/mips_execute_alu_stage_pkg.sv | 45 ++++
 rtl/mips_execute_alu_stage_multiplier.sv | 84 ++++++++
 rtl/mips_execute_alu_stage.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mips_execute_alu_stage_pkg.sv
// ---------------------------------------------------------------------------
// mips_execute_alu_stage_pkg
// Shared definitions for the MIPS execute/ALU stage:
//   - alu_op_e         : ALU operation encodings
//   - data2_source_e   : operand-2 source select (Register / Immediate / Shamt)
//   - alu_control_t    : control bundle presented by decode
//   - mult_state_e     : multiplier FSM state encoding
// ---------------------------------------------------------------------------
package mips_execute_alu_stage_pkg;

    typedef enum logic [1:0] {
        SRC_REGISTER  = 2'd0,
        SRC_IMMEDIATE = 2'd1,
        SRC_SHAMT     = 2'd2
    } data2_source_e;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOR   = 4'd5,
        OP_SLT   = 4'd6,
        OP_SLTU  = 4'd7,
        OP_SLL   = 4'd8,
        OP_SRL   = 4'd9,
        OP_SRA   = 4'd10,
        OP_LUI   = 4'd11,
        OP_MFHI  = 4'd12,
        OP_MFLO  = 4'd13,
        OP_MULTU = 4'd14
    } alu_op_e;

    typedef struct packed {
        data2_source_e data2_source;
        alu_op_e       operation;
    } alu_control_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MULT = 1'b1
    } mult_state_e;

endpackage

// File: rtl/mips_execute_alu_stage_multiplier.sv
// ---------------------------------------------------------------------------
// mips_execute_alu_stage_multiplier
// Iterative unsigned shift-add multiplier, one multiplier bit per clock.
// Ports:
//   i_clock, i_reset     : clock, synchronous active-high reset
//   i_start              : begin a multiply (sampled only while idle)
//   i_multiplicand       : first operand
//   i_multiplier         : second operand
//   o_busy               : FSM is in MULT (32 cycles after the start edge)
//   o_done               : high during the final iteration cycle
//   o_product            : full product, valid while o_done is high; the
//                          owner captures it on that same edge
// ---------------------------------------------------------------------------
module mips_execute_alu_stage_multiplier
    import mips_execute_alu_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_multiplicand,
    input  logic [WIDTH-1:0]     i_multiplier,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    mult_state_e          r_state;
    logic [5:0]           r_count;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;

    logic [2*WIDTH-1:0]   w_next_acc;
    logic                 w_last;

    // Partial product for the current multiplier bit; the multiplicand is
    // pre-shifted so bit k lines up with weight 2^k.
    assign w_next_acc = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_last     = (r_state == ST_MULT) && (r_count == 6'(WIDTH - 1));

    assign o_busy    = (r_state == ST_MULT);
    assign o_done    = w_last;
    assign o_product = w_next_acc;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state  <= ST_MULT;
                        r_count  <= '0;
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, i_multiplicand};
                        r_mplier <= i_multiplier;
                    end
                end
                ST_MULT: begin
                    r_acc    <= w_next_acc;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (w_last) begin
                        r_state <= ST_IDLE;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + 6'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mips_execute_alu_stage.sv
// ---------------------------------------------------------------------------
// mips_execute_alu_stage
// MIPS execute stage: combinational ALU feeding a single output register,
// plus HI/LO registers written by an iterative MULTU unit.
// Ports:
//   i_clock, i_reset   : clock, synchronous active-high reset
//   i_in_valid         : decode presents an instruction
//   i_control          : operand-2 source and ALU operation
//   i_data1            : rs operand
//   i_data2_register   : rt operand
//   i_immediate        : already-extended immediate
//   i_shamt            : shamt field
//   i_stall            : downstream cannot accept; hold the output register
//   i_flush            : drop the presented instruction and clear outValid
//   o_busy             : multiplier occupied; decode must hold
//   o_out_valid        : o_result holds a live instruction
//   o_result           : registered ALU result
//   o_hi, o_lo         : multiply result registers
// ---------------------------------------------------------------------------
module mips_execute_alu_stage
    import mips_execute_alu_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_in_valid,
    input  alu_control_t      i_control,
    input  logic [WIDTH-1:0]  i_data1,
    input  logic [WIDTH-1:0]  i_data2_register,
    input  logic [WIDTH-1:0]  i_immediate,
    input  logic [4:0]        i_shamt,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic              o_busy,
    output logic              o_out_valid,
    output logic [WIDTH-1:0]  o_result,
    output logic [WIDTH-1:0]  o_hi,
    output logic [WIDTH-1:0]  o_lo
);

    logic                     r_out_valid;
    logic [WIDTH-1:0]         r_result;
    logic [WIDTH-1:0]         r_hi;
    logic [WIDTH-1:0]         r_lo;

    logic [WIDTH-1:0]         w_operand2;
    logic signed [WIDTH-1:0]  w_data1_s;
    logic signed [WIDTH-1:0]  w_operand2_s;
    logic signed [WIDTH-1:0]  w_data2_s;
    logic [4:0]               w_shift;
    logic                     w_accept;
    logic                     w_is_multu;
    logic [WIDTH-1:0]         w_alu_result;
    logic                     w_mult_busy;
    logic                     w_mult_done;
    logic [2*WIDTH-1:0]       w_mult_product;

    always_comb begin
        w_operand2 = i_data2_register;
        case (i_control.data2_source)
            SRC_REGISTER:  w_operand2 = i_data2_register;
            SRC_IMMEDIATE: w_operand2 = i_immediate;
            SRC_SHAMT:     w_operand2 = {{(WIDTH-5){1'b0}}, i_shamt};
            default:       w_operand2 = i_data2_register;
        endcase
    end

    assign w_data1_s    = $signed(i_data1);
    assign w_operand2_s = $signed(w_operand2);
    assign w_data2_s    = $signed(i_data2_register);
    // Shifts always move rt; operand 2 only supplies the distance.
    assign w_shift      = w_operand2[4:0];

    assign w_is_multu = (i_control.operation == OP_MULTU);
    assign w_accept   = i_in_valid && !i_stall && !w_mult_busy && !i_flush;

    always_comb begin
        w_alu_result = '0;
        case (i_control.operation)
            OP_ADD:  w_alu_result = i_data1 + w_operand2;
            OP_SUB:  w_alu_result = i_data1 - w_operand2;
            OP_AND:  w_alu_result = i_data1 & w_operand2;
            OP_OR:   w_alu_result = i_data1 | w_operand2;
            OP_XOR:  w_alu_result = i_data1 ^ w_operand2;
            OP_NOR:  w_alu_result = ~(i_data1 | w_operand2);
            OP_SLT:  w_alu_result = {{(WIDTH-1){1'b0}}, (w_data1_s < w_operand2_s)};
            OP_SLTU: w_alu_result = {{(WIDTH-1){1'b0}}, (i_data1 < w_operand2)};
            OP_SLL:  w_alu_result = i_data2_register << w_shift;
            OP_SRL:  w_alu_result = i_data2_register >> w_shift;
            OP_SRA:  w_alu_result = $unsigned(w_data2_s >>> w_shift);
            OP_LUI:  w_alu_result = {i_immediate[15:0], 16'h0000};
            OP_MFHI: w_alu_result = r_hi;
            OP_MFLO: w_alu_result = r_lo;
            default: w_alu_result = '0;
        endcase
    end

    mips_execute_alu_stage_multiplier #(
        .WIDTH (WIDTH)
    ) u_multiplier (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_start        (w_accept && w_is_multu),
        .i_multiplicand (i_data1),
        .i_multiplier   (i_data2_register),
        .o_busy         (w_mult_busy),
        .o_done         (w_mult_done),
        .o_product      (w_mult_product)
    );

    // Output register and HI/LO. HI/LO load on the final multiply edge, the
    // same edge busy falls, so an MFHI/MFLO accepted in the next cycle sees
    // the new product. Flush and stall never touch the multiplier.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            if (w_mult_done) begin
                r_hi <= w_mult_product[2*WIDTH-1:WIDTH];
                r_lo <= w_mult_product[WIDTH-1:0];
            end
            if (i_flush) begin
                r_out_valid <= 1'b0;
            end else if (!i_stall) begin
                if (w_accept) begin
                    // MULTU retires through HI/LO, not through the result bus.
                    r_out_valid <= !w_is_multu;
                    r_result    <= w_alu_result;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign o_busy      = w_mult_busy;
    assign o_out_valid = r_out_valid;
    assign o_result    = r_result;
    assign o_hi        = r_hi;
    assign o_lo        = r_lo;

endmodule
